// File: rtl/muldiv_unit_pkg.sv
// Shared encodings for the multiply/divide unit: operation codes and FSM state values.
package muldiv_unit_pkg;

  typedef logic [1:0] op_t;

  localparam op_t OpMult  = 2'd0;
  localparam op_t OpMultu = 2'd1;
  localparam op_t OpDiv   = 2'd2;
  localparam op_t OpDivu  = 2'd3;

  typedef logic [1:0] state_t;

  localparam state_t StIdle = 2'd0;
  localparam state_t StRun  = 2'd1;
  localparam state_t StFix  = 2'd2;

  function automatic logic op_is_signed(op_t op);
    return (op == OpMult) || (op == OpDiv);
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/result bundle between a pipeline front end (master) and the mul/div unit (slave).
interface muldiv_unit_if
  import muldiv_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  op_t              op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             wen_hi;
  logic             wen_lo;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, wen_hi, wen_lo, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, wen_hi, wen_lo, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: magnitudes are processed over WIDTH cycles in one
// 2*WIDTH shift register with a single WIDTH+1 adder, then signs are fixed up in one cycle.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input logic         clk,
  input logic         rst,
  muldiv_unit_if.slave bus
);

  localparam int unsigned     CntW    = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] CntInit = CntW'(WIDTH);

  state_t             state_q, state_d;
  op_t                op_q, op_d;
  logic               sa_q, sa_d, sb_q, sb_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d;

  // Single conditional negator used for operand magnitudes and result sign fix-up.
  function automatic logic [WIDTH-1:0] cneg(input logic [WIDTH-1:0] v, input logic en,
                                            input logic cin);
    return en ? (~v + WIDTH'(cin)) : v;
  endfunction

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               is_mul, is_signed, q_sign, neg_lo, neg_hi, hi_cin;
  logic [WIDTH:0]     add_x, add_y, add_s;
  logic [2*WIDTH-1:0] mul_next, div_next;
  logic [WIDTH-1:0]   res_hi, res_lo, fix_hi, fix_lo;

  always_comb begin
    a_neg = op_is_signed(bus.op) & bus.a[WIDTH-1];
    b_neg = op_is_signed(bus.op) & bus.b[WIDTH-1];
    a_mag = cneg(bus.a, a_neg, 1'b1);
    b_mag = cneg(bus.b, b_neg, 1'b1);

    is_mul    = ~op_q[1];
    is_signed = op_is_signed(op_q);

    // Multiply adds the multiplicand to the upper half; divide subtracts the divisor from
    // the partial remainder shifted left by one.
    add_x = is_mul ? {1'b0, acc_q[2*WIDTH-1:WIDTH]} : acc_q[2*WIDTH-1:WIDTH-1];
    add_y = {1'b0, opnd_q} ^ {(WIDTH + 1){op_q[1]}};
    add_s = add_x + add_y + (WIDTH + 1)'(op_q[1]);

    mul_next = {(acc_q[0] ? add_s : add_x), acc_q[WIDTH-1:1]};
    div_next = add_s[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                            : {add_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    res_hi = acc_q[2*WIDTH-1:WIDTH];
    res_lo = acc_q[WIDTH-1:0];
    q_sign = is_signed & (sa_q ^ sb_q);
    // A zero divisor leaves an all-ones quotient that must not be negated.
    neg_lo = is_mul ? q_sign : (q_sign & (opnd_q != '0));
    neg_hi = is_mul ? q_sign : (is_signed & sa_q);
    hi_cin = is_mul ? (res_lo == '0) : 1'b1;
    fix_lo = cneg(res_lo, neg_lo, 1'b1);
    fix_hi = cneg(res_hi, neg_hi, hi_cin);
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.wen_hi) hi_d = bus.wdata;
        if (bus.wen_lo) lo_d = bus.wdata;
        if (bus.start) begin
          op_d    = bus.op;
          sa_d    = a_neg;
          sb_d    = b_neg;
          cnt_d   = CntInit;
          state_d = StRun;
          if (bus.op[1]) begin
            opnd_d = b_mag;
            acc_d  = {{WIDTH{1'b0}}, a_mag};
          end else begin
            opnd_d = a_mag;
            acc_d  = {{WIDTH{1'b0}}, b_mag};
          end
        end
      end
      StRun: begin
        acc_d = op_q[1] ? div_next : mul_next;
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) state_d = StFix;
      end
      StFix: begin
        hi_d    = fix_hi;
        lo_d    = fix_lo;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= OpMult;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      opnd_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = (state_q != StIdle);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule
